// File: rtl/stream_credit_sender.sv
// Credit-gated stream front end for a downstream FIFO without backpressure.
// Buffers upstream words locally; pushes only while credits remain.
module stream_credit_sender #(
  parameter int DATA_WIDTH = 32,
  parameter int CREDITS    = 4,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [DATA_WIDTH-1:0]          in_data_i,
  output logic                           out_valid_o,
  output logic [DATA_WIDTH-1:0]          out_data_o,
  input  logic                           credit_return_i,
  output logic [$clog2(CREDITS+1)-1:0]   credits_o,
  output logic                           idle_o,
  output logic                           err_o
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  localparam logic [CW-1:0] CMAX  = CW'(CREDITS);
  localparam logic [OW-1:0] OMAX  = OW'(BUF_DEPTH);
  localparam logic [PW-1:0] PLAST = PW'(BUF_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [OW-1:0]         occ;
  logic [OW-1:0]         occ_next;
  logic [CW-1:0]         credits;
  logic [CW-1:0]         credits_next;
  logic                  err;
  logic                  err_next;
  logic                  empty;
  logic                  full;
  logic                  accept;
  logic                  send;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PLAST) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (occ == '0);
  assign full   = (occ == OMAX);

  // No pass-through when full: ready depends only on stored occupancy.
  assign in_ready_o  = !full && !flush;
  assign accept      = in_valid_i && in_ready_o;

  // Reset also gates the strobe so nothing leaks out in the reset cycle.
  assign send        = !empty && (credits != '0) && !flush && !rst;
  assign out_valid_o = send;
  assign out_data_o  = empty ? '0 : mem[rd_ptr];

  assign credits_o = credits;
  assign idle_o    = empty && (credits == CMAX);
  assign err_o     = err;

  // Next credit count and occupancy; overflowing return saturates and flags.
  always_comb begin
    credits_next = credits;
    err_next     = err;
    occ_next     = occ;
    if (send && !credit_return_i) begin
      credits_next = credits - 1'b1;
    end else if (!send && credit_return_i) begin
      if (credits == CMAX) begin
        err_next = 1'b1;
      end else begin
        credits_next = credits + 1'b1;
      end
    end
    if (accept && !send) begin
      occ_next = occ + 1'b1;
    end else if (!accept && send) begin
      occ_next = occ - 1'b1;
    end
  end

  // Control state: reset, then flush, then normal update.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      occ     <= '0;
      credits <= CMAX;
      err     <= 1'b0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      occ     <= '0;
      credits <= CMAX;
    end else begin
      occ     <= occ_next;
      credits <= credits_next;
      err     <= err_next;
      if (accept) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (send) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  // Payload storage; contents are don't-care until occupancy covers them.
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      mem[wr_ptr] <= in_data_i;
    end
  end

endmodule

// File: tb/tb_stream_credit_sender.sv
// Directed checks for stream_credit_sender.
// Default instance plus a BUF_DEPTH=3, CREDITS=5 instance.
module tb_stream_credit_sender;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, credit_ret;
  logic [31:0] in_data;
  logic        in_ready, out_valid, idle, err;
  logic [31:0] out_data;
  logic [2:0]  credits;

  stream_credit_sender dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data),
    .out_valid_o(out_valid), .out_data_o(out_data),
    .credit_return_i(credit_ret), .credits_o(credits),
    .idle_o(idle), .err_o(err)
  );

  logic       rst2, flush2, in_valid2, credit_ret2;
  logic [7:0] in_data2;
  logic       in_ready2, out_valid2, idle2, err2;
  logic [7:0] out_data2;
  logic [2:0] credits2;

  stream_credit_sender #(
    .DATA_WIDTH(8), .CREDITS(5), .BUF_DEPTH(3)
  ) dut2 (
    .clk(clk), .rst(rst2), .flush(flush2),
    .in_valid_i(in_valid2), .in_ready_o(in_ready2),
    .in_data_i(in_data2),
    .out_valid_o(out_valid2), .out_data_o(out_data2),
    .credit_return_i(credit_ret2), .credits_o(credits2),
    .idle_o(idle2), .err_o(err2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int nexp;
    int rets;
    rst = 1; flush = 0; in_valid = 0; credit_ret = 0; in_data = 0;
    rst2 = 1; flush2 = 0; in_valid2 = 0; credit_ret2 = 0; in_data2 = 0;
    tick();
    rst = 0; rst2 = 0;
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idle", idle, 1);
    chk("rst_credits", credits, 4);
    chk("rst_err", err, 0);

    // Back-to-back A0..A3, no returns.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = 32'hA0 + i;
      #1;
      chk("a_ready", in_ready, 1);
      chk("a_credits", credits, (i == 0) ? 4 : 5 - i);
      if (i > 0) begin
        chk("a_valid", out_valid, 1);
        chk("a_data", out_data, 32'hA0 + i - 1);
      end else begin
        chk("a_valid0", out_valid, 0);
      end
      tick();
    end

    // B0 accepted while A3 goes out with the last credit.
    in_data = 32'hB0;
    #1;
    chk("a3_valid", out_valid, 1);
    chk("a3_data", out_data, 32'hA3);
    chk("a3_credits", credits, 1);
    tick();
    in_data = 32'hB1;
    #1;
    chk("b1_ready", in_ready, 1);
    chk("b1_valid", out_valid, 0);
    chk("b1_credits", credits, 0);
    tick();
    in_data = 32'hB2;
    #1;
    chk("b2_ready", in_ready, 0);
    chk("b2_valid", out_valid, 0);
    tick();
    credit_ret = 1;
    #1;
    chk("b2_ready2", in_ready, 0);
    chk("b2_valid2", out_valid, 0);
    tick();
    credit_ret = 0;
    #1;
    chk("b0_valid", out_valid, 1);
    chk("b0_data", out_data, 32'hB0);
    chk("b0_credits", credits, 1);
    chk("b0_nopass", in_ready, 0);
    tick();
    #1;
    chk("b0_cred_after", credits, 0);
    chk("b0_valid_after", out_valid, 0);
    chk("b2_ready3", in_ready, 1);
    tick();

    // Two buffered (B1,B2), credits 0 -> get one credit, then flush.
    in_valid = 0; credit_ret = 1;
    tick();
    #1;
    chk("fl_pre_credits", credits, 1);
    chk("fl_pre_valid", out_valid, 1);
    chk("fl_pre_data", out_data, 32'hB1);
    flush = 1; credit_ret = 1;
    #1;
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 0);
    tick();
    flush = 0; credit_ret = 0;
    #1;
    chk("fl_post_valid", out_valid, 0);
    chk("fl_post_data", out_data, 0);
    chk("fl_post_credits", credits, 4);
    chk("fl_post_idle", idle, 1);
    chk("fl_post_err", err, 0);

    // Overflowing return at idle.
    credit_ret = 1;
    tick();
    credit_ret = 0;
    #1;
    chk("ov_credits", credits, 4);
    chk("ov_err", err, 1);
    flush = 1;
    tick();
    flush = 0;
    #1;
    chk("ov_err_flush", err, 1);
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("ov_err_rst", err, 0);
    chk("ov_idle_rst", idle, 1);

    // Steady streaming: returns every cycle from cycle 4.
    for (int c = 0; c <= 32; c++) begin
      in_valid   = (c < 32);
      in_data    = 32'h100 + c;
      credit_ret = (c >= 4);
      #1;
      if (c >= 1) begin
        chk("ss_valid", out_valid, 1);
        chk("ss_data", out_data, 32'h100 + c - 1);
      end
      if (c >= 5) chk("ss_credits", credits, 1);
      tick();
    end
    in_valid = 0; credit_ret = 0;
    #1;
    chk("ss_end_valid", out_valid, 0);
    chk("ss_end_credits", credits, 1);

    // Second instance: wrap across 3-entry buffer with stalls.
    acc = 0; nexp = 0; rets = 0;
    for (int c = 0; c < 60; c++) begin
      in_valid2   = (acc < 10);
      in_data2    = 8'h30 + 8'(acc);
      credit_ret2 = (c >= 8) && (c % 2 == 0) && (rets < 5);
      #1;
      if (out_valid2) begin
        chk("wr_data", out_data2, 32'h30 + nexp);
        nexp++;
      end
      if (in_valid2 && in_ready2) acc++;
      if (credit_ret2) rets++;
      tick();
    end
    in_valid2 = 0; credit_ret2 = 0;
    #1;
    chk("wr_count", nexp, 10);
    chk("wr_credits", credits2, 0);
    chk("wr_err", err2, 0);

    // Reset mid-burst with a send pending.
    in_valid2 = 1; in_data2 = 8'h50; credit_ret2 = 1;
    tick();
    credit_ret2 = 0; in_data2 = 8'h51; rst2 = 1;
    #1;
    chk("mr_valid_in_rst", out_valid2, 0);
    tick();
    rst2 = 0; in_valid2 = 0;
    #1;
    chk("mr_ready", in_ready2, 1);
    chk("mr_valid", out_valid2, 0);
    chk("mr_credits", credits2, 5);
    chk("mr_idle", idle2, 1);
    chk("mr_data", out_data2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_credit_sender.md
Name: stream_credit_sender

Overview:
- Producer-side front end for a downstream stream FIFO that exposes no full/ready indication and silently drops writes when full.
- The block accepts a valid/ready stream, buffers it locally, and pushes words into the FIFO only while it holds credit.
- Each pop performed at the FIFO's read side returns one credit to the block.
- A shared flush clears both this block and the downstream FIFO in the same cycle.

Parameters:
- DATA_WIDTH, 32, payload width.
- CREDITS, 4, depth of the downstream FIFO and initial credit count; must be >= 1.
- BUF_DEPTH, 2, local buffer entries; must be >= 1.

Ports:
- clk, input, 1, clock; all logic is rising-edge.
- rst, input, 1, synchronous active-high reset.
- flush, input, 1, synchronous clear; driven to the downstream FIFO in the same cycle.
- in_valid_i, input, 1, upstream word valid.
- in_ready_o, output, 1, block can accept a word.
- in_data_i, input, DATA_WIDTH, upstream payload.
- out_valid_o, output, 1, push strobe to the downstream FIFO write-valid.
- out_data_o, output, DATA_WIDTH, payload to the downstream FIFO write-data.
- credit_return_i, input, 1, one-cycle pulse per downstream pop (FIFO read-ready and not empty).
- credits_o, output, $clog2(CREDITS+1), current credit count.
- idle_o, output, 1, high when the buffer is empty and credits_o equals CREDITS.
- err_o, output, 1, sticky credit-overflow flag.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: buffer empty, rd/wr pointers 0, credit count = CREDITS, err_o = 0.
  - Resulting outputs: in_ready_o = 1, out_valid_o = 0, out_data_o = 0, idle_o = 1.
- Local buffer:
  - Circular FIFO of BUF_DEPTH entries with an occupancy counter of width $clog2(BUF_DEPTH+1).
  - Pointers wrap from BUF_DEPTH-1 to 0; non-power-of-2 depths are supported.
- Input handshake:
  - accept = in_valid_i && in_ready_o.
  - in_ready_o = (occupancy != BUF_DEPTH) && !flush.
  - When the buffer is full there is no pass-through, even if a send occurs in the same cycle.
- Send:
  - send = (occupancy != 0) && (credits != 0) && !flush.
  - out_valid_o = send; out_data_o = head entry while occupancy != 0, else 0.
  - A send consumes the head entry and one credit on the same edge.
  - The downstream FIFO is guaranteed not full, so every out_valid_o cycle is a completed push. The block has no backpressure input.
- Latency:
  - A word accepted at edge N, into an empty buffer with credits > 0, appears on out_valid_o in the cycle after edge N.
  - Sustained throughput is 1 word/cycle while credits are nonzero.
- Credit update, applied each edge when not flushing:
  - credits_next = credits - send + credit_return_i.
  - Send and return in the same cycle leave the count unchanged.
  - A return when credits == CREDITS with no send is a protocol error: the count saturates at CREDITS and err_o sets.
- Occupancy update: occ_next = occ + accept - send. Simultaneous accept and send leave occupancy unchanged and advance both pointers.
- Flush, highest priority after rst:
  - Buffer emptied, pointers cleared, credits = CREDITS.
  - credit_return_i is ignored that cycle; in_data_i is not accepted; out_valid_o = 0.
  - err_o is not cleared by flush; only rst clears err_o.
- Zero credits: buffered words are held and out_valid_o = 0. A credit_return_i pulse makes out_valid_o rise on the following cycle.
- Reset mid-stream: buffered words are discarded, there is no output activity in the reset cycle, and state matches the reset values on the next cycle.

Test Plan:
- Reset, then push 0xA0..0xA3 back-to-back with no returns:
  - out_valid_o pulses 4 cycles carrying 0xA0..0xA3 in order, each one cycle after acceptance.
  - credits_o steps 4 to 0.
- Continue pushing 0xB0, 0xB1, 0xB2 with credits = 0:
  - Two words are buffered, then in_ready_o drops to 0 and 0xB2 is held.
  - out_valid_o stays 0.
  - One credit_return_i pulse: 0xB0 is sent on the next cycle and credits_o returns to 0.
- Steady state, in_valid_i = 1 every cycle and credit_return_i = 1 every cycle from cycle 4:
  - After the initial 4 sends, exactly 1 word/cycle leaves and credits_o holds constant.
  - There are no gaps and no reordering over 32 words.
- Flush with 2 words buffered, credits_o = 1, and credit_return_i = 1 in the same cycle:
  - The next cycle shows occupancy 0, credits_o = 4, idle_o = 1, and no out_valid_o for the flushed words.
  - err_o stays 0.
- credit_return_i pulsed at idle (credits_o = 4): credits_o stays 4, err_o = 1 and stays set through a subsequent flush, and is cleared only by rst.
- Assert rst mid-burst with BUF_DEPTH = 3, CREDITS = 5:
  - The next cycle shows in_ready_o = 1, out_valid_o = 0, credits_o = 5.
  - Pointer wrap is checked with 10 words: output order is preserved across the 2→0 wrap.
